seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_match_core.sv | 52 +++++
 rtl/seq_det_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Pattern loaded by reset; narrower instances take the low PAT_W bits.
    localparam logic [7:0] DEF_PATTERN = 8'b0110;

endpackage

// File: rtl/seq_match_core.sv
// Serial match datapath: history shift register, fill counter and the
// combinational Mealy comparator that produces z.
module seq_match_core #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             armed,
    input  logic             x_valid,
    input  logic             abort,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    output logic             z
);

    localparam int HIST_W = PAT_W - 1;
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (armed && x_valid) begin
            // Drop the oldest bit; the newest bit lands in bit 0.
            hist_d = HIST_W'({hist_q, x});
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign z = reset && armed && x_valid && !abort
               && (fill_q == FILL_FULL) && ({hist_q, x} == pattern);

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: config latch, IDLE/ARMED/DONE
// FSM and saturating match counter around a single seq_match_core.
// Handshake: cfg_valid/cfg_ready transfer when both are high at a clk edge;
// cfg_ready is high only in IDLE and does not depend on cfg_valid.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             abort,
    input  logic             x_valid,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cfg_fire;
    logic             clear;
    logic             armed;

    assign armed    = (state_q == ST_ARMED);
    assign cfg_fire = cfg_valid && (state_q == ST_IDLE);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        thresh_d  = thresh_q;
        cnt_d     = cnt_q;
        clear     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    pattern_d = cfg_pattern;
                    thresh_d  = cfg_thresh;
                end else if (start) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (z) begin
                    cnt_d = cnt_inc;
                    if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= DEF_PATTERN[PAT_W-1:0];
            thresh_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            thresh_q  <= thresh_d;
            cnt_q     <= cnt_d;
        end
    end

    seq_match_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .armed  (armed),
        .x_valid(x_valid),
        .abort  (abort),
        .x      (x),
        .pattern(pattern_q),
        .z      (z)
    );

    // Status outputs are forced to their reset values while reset is low.
    assign cfg_ready = (state_q == ST_IDLE) || !reset;
    assign busy      = armed && reset;
    assign done      = (state_q == ST_DONE) && reset;
    assign match_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule
